// File: rtl/mem_bank_arbiter.sv
// mem_bank_arbiter: arbitrates core loads/stores into the local data bank owned by BANK_ID.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the lowest eligible index wins.
module mem_bank_arbiter #(
    parameter int BANK_ID       = 0,
    parameter int CORE_COUNT    = 4,
    parameter int CORE_ID_WIDTH = 2,
    parameter int REG_WIDTH     = 8
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [2*CORE_COUNT-1:0]                       enable_M,
    input  logic [CORE_COUNT*(CORE_ID_WIDTH+REG_WIDTH)-1:0] addr_M,
    input  logic [CORE_COUNT*REG_WIDTH-1:0]               wr_data_M,
    output logic [CORE_COUNT*REG_WIDTH-1:0]               rd_data_M,
    output logic [CORE_COUNT-1:0]                         ready_M
);
    localparam int AW = CORE_ID_WIDTH + REG_WIDTH;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic [REG_WIDTH-1:0] bank [2**REG_WIDTH];
    logic [CORE_COUNT-1:0] elig, cand;
    logic [CORE_ID_WIDTH-1:0] win, pick;
    logic pick_vld, grant, is_st;
    logic [1:0] sel_op;
    logic [REG_WIDTH-1:0] off, wdata, rdata, sel_off, sel_wd;
    int start;

    always_comb begin
        elig = '0;
        for (int i = 0; i < CORE_COUNT; i++)
            elig[i] = (enable_M[2*i +: 2] == 2'b01 || enable_M[2*i +: 2] == 2'b10) &&
                      addr_M[i*AW+REG_WIDTH +: CORE_ID_WIDTH] == CORE_ID_WIDTH'(BANK_ID);
    end

    // In RESP ready_M is exactly the current winner, so this drops it from the contest.
    assign cand = elig & ~ready_M;

`ifdef MEM_ARB_RR_EN
    logic [CORE_ID_WIDTH-1:0] ptr, nxt_win;
    assign nxt_win = (win == CORE_ID_WIDTH'(CORE_COUNT-1)) ? '0 : win + 1'b1;
    assign start = (state == RESP) ? int'(nxt_win) : int'(ptr);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ptr <= '0;
        else if (state == RESP) ptr <= nxt_win;
    end
`else
    assign start = 0;
`endif

    always_comb begin
        pick = '0;
        pick_vld = 1'b0;
        for (int k = CORE_COUNT-1; k >= 0; k--)
            for (int i = 0; i < CORE_COUNT; i++)
                if (cand[i] && i == (start + k) % CORE_COUNT) begin
                    pick = CORE_ID_WIDTH'(i);
                    pick_vld = 1'b1;
                end
    end

    always_comb begin
        sel_op = '0;
        sel_off = '0;
        sel_wd = '0;
        for (int i = 0; i < CORE_COUNT; i++)
            if (pick == CORE_ID_WIDTH'(i)) begin
                sel_op = enable_M[2*i +: 2];
                sel_off = addr_M[i*AW +: REG_WIDTH];
                sel_wd = wr_data_M[i*REG_WIDTH +: REG_WIDTH];
            end
    end

    assign grant = pick_vld && (state == IDLE || state == RESP);
    assign state_nx = (state == ACCESS) ? RESP : (grant ? ACCESS : IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            win <= '0;
            is_st <= 1'b0;
            off <= '0;
            wdata <= '0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            if (grant) begin
                win <= pick;
                is_st <= sel_op == 2'b10;
                off <= sel_off;
                wdata <= sel_wd;
            end
            if (state == ACCESS) rdata <= is_st ? '0 : bank[off];
        end
    end

    // Bank is not reset; an async reset during ACCESS leaves state IDLE at the edge, so no write.
    always_ff @(posedge clk) begin
        if (state == ACCESS && is_st) bank[off] <= wdata;
    end

    always_comb begin
        ready_M = '0;
        rd_data_M = '0;
        for (int i = 0; i < CORE_COUNT; i++)
            if (state == RESP && win == CORE_ID_WIDTH'(i)) begin
                ready_M[i] = 1'b1;
                rd_data_M[i*REG_WIDTH +: REG_WIDTH] = rdata;
            end
    end
endmodule

// File: tb/tb_mem_bank_arbiter.sv
// tb_mem_bank_arbiter: directed scoreboard bench for mem_bank_arbiter (BANK_ID 0, four cores).
module tb_mem_bank_arbiter;
    logic clk = 1'b0;
    logic reset;
    logic [7:0] enable_M;
    logic [39:0] addr_M;
    logic [31:0] wr_data_M;
    logic [31:0] rd_data_M;
    logic [3:0] ready_M;

    typedef struct {int c; logic [7:0] d; int at;} exp_t;
    exp_t sb[$];
    int tests = 0, fails = 0, cyc = 0;
    int cnt[4];
    bit sb_on;

    mem_bank_arbiter dut (
        .clk(clk), .reset(reset), .enable_M(enable_M), .addr_M(addr_M),
        .wr_data_M(wr_data_M), .rd_data_M(rd_data_M), .ready_M(ready_M)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int c, logic [1:0] op, logic [1:0] bk, logic [7:0] off, logic [7:0] d);
        enable_M[2*c +: 2] = op;
        addr_M[10*c +: 10] = {bk, off};
        wr_data_M[8*c +: 8] = d;
    endtask

    task automatic expect_resp(int c, logic [7:0] d, int at);
        exp_t e;
        e.c = c;
        e.d = d;
        e.at = at;
        sb.push_back(e);
    endtask

    task automatic wait_done(int c);
        bit seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = ready_M[c];
        end
        check($sformatf("done_core%0d", c), seen, 1);
        tick();
        drive(c, 2'b00, 2'b00, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    always @(negedge clk) begin
        check("onehot", 64'($onehot0(ready_M)), 1);
        if (ready_M == '0) check("idle_rd", rd_data_M, 0);
        else begin
            int c;
            exp_t e;
            c = 0;
            for (int i = 0; i < 4; i++) if (ready_M[i]) c = i;
            if (!sb_on) cnt[c]++;
            else if (sb.size() == 0) check("unexpected", ready_M, 0);
            else begin
                e = sb.pop_front();
                check("resp_core", c, e.c);
                check("resp_data", rd_data_M[8*c +: 8], e.d);
                check("resp_cycle", cyc, e.at);
                check("rd_other", rd_data_M & ~(32'hFF << (8*c)), 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1;
        enable_M = '0;
        addr_M = '0;
        wr_data_M = '0;
        sb_on = 1'b1;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", ready_M, 0);
        check("rst_rd", rd_data_M, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        // store then load, same core and offset
        drive(1, 2'b10, 2'b00, 8'h10, 8'h5A); expect_resp(1, 8'h00, cyc + 2); wait_done(1);
        drive(1, 2'b01, 2'b00, 8'h10, 8'h00); expect_resp(1, 8'h5A, cyc + 2); wait_done(1);
        drive(3, 2'b10, 2'b00, 8'h20, 8'hC3); expect_resp(3, 8'h00, cyc + 2); wait_done(3);
        drive(2, 2'b10, 2'b00, 8'h30, 8'h3C); expect_resp(2, 8'h00, cyc + 2); wait_done(2);
        drive(0, 2'b10, 2'b00, 8'hFF, 8'h96); expect_resp(0, 8'h00, cyc + 2); wait_done(0);
        drive(2, 2'b01, 2'b00, 8'hFF, 8'h00); expect_resp(2, 8'h96, cyc + 2); wait_done(2);
        // simultaneous loads from a freshly reset arbiter; bank contents survive reset
        do_reset();
        drive(0, 2'b01, 2'b00, 8'h10, 8'h00);
        drive(1, 2'b01, 2'b00, 8'h20, 8'h00);
        drive(3, 2'b01, 2'b00, 8'h30, 8'h00);
        expect_resp(0, 8'h5A, cyc + 2);
        expect_resp(1, 8'hC3, cyc + 4);
        expect_resp(3, 8'h3C, cyc + 6);
        wait_done(0); wait_done(1); wait_done(3);
        // cores 0,1,3 hold requests continuously
        sb_on = 1'b0;
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        drive(0, 2'b01, 2'b00, 8'h10, 8'h00);
        drive(1, 2'b01, 2'b00, 8'h20, 8'h00);
        drive(3, 2'b01, 2'b00, 8'h30, 8'h00);
        repeat (20) tick();
        enable_M = '0;
        repeat (4) tick();
        check("core0_served", cnt[0] != 0, 1);
`ifdef MEM_ARB_RR_EN
        check("rr_core3_served", cnt[3] != 0, 1);
`else
        check("fp_core3_starved", cnt[3], 0);
`endif
        sb_on = 1'b1;
        // foreign bank id and reserved op are ignored
        drive(2, 2'b01, 2'b01, 8'h10, 8'h00);
        n = 0;
        repeat (20) begin @(negedge clk); if (ready_M != 0) n++; end
        check("foreign_bank", n, 0);
        tick();
        drive(2, 2'b00, 2'b00, 8'h00, 8'h00);
        drive(0, 2'b11, 2'b00, 8'h10, 8'h77);
        n = 0;
        repeat (20) begin @(negedge clk); if (ready_M != 0) n++; end
        check("op_11", n, 0);
        tick();
        drive(0, 2'b00, 2'b00, 8'h00, 8'h00);
        // reset during ACCESS of a store aborts it; first grant on first posedge after release
        drive(0, 2'b10, 2'b00, 8'h03, 8'h11); expect_resp(0, 8'h00, cyc + 2); wait_done(0);
        drive(0, 2'b10, 2'b00, 8'h03, 8'hFF);
        tick();
        reset = 1'b0;
        #1;
        check("abort_ready", ready_M, 0);
        check("abort_rd", rd_data_M, 0);
        drive(0, 2'b01, 2'b00, 8'h03, 8'h00);
        tick();
        @(negedge clk);
        expect_resp(0, 8'h11, cyc + 2);
        reset = 1'b1;
        wait_done(0);
        // all four cores continuously requesting
        sb_on = 1'b0;
        for (int i = 0; i < 4; i++) drive(i, 2'b01, 2'b00, 8'h10, 8'h00);
        repeat (3) tick();
        n = 0;
        repeat (100) begin @(negedge clk); if (ready_M != 0) n++; end
        check("throughput", n, 50);
        tick();
        enable_M = '0;
        repeat (4) tick();
        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_bank_arbiter.md
MEM_BANK_ARBITER -- requirements
Module: mem_bank_arbiter

Interface
REQ-001 Parameter BANK_ID, default 0: index of the core whose local data bank this instance owns.
REQ-002 Parameter CORE_COUNT, default 4: number of requesting cores; CORE_ID_WIDTH, default 2, is log2(CORE_COUNT).
REQ-003 Parameter REG_WIDTH, default 8: data width and bank offset width; bank depth is 2^REG_WIDTH words.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 enable_M  in  2*CORE_COUNT  per-core op, slice i = bits [2i+1:2i]: 01 load, 10 store, 00/11 no request.
REQ-007 addr_M  in  CORE_COUNT*(CORE_ID_WIDTH+REG_WIDTH)  per-core address; slice = {bank id, offset}.
REQ-008 wr_data_M  in  CORE_COUNT*REG_WIDTH  per-core store data.
REQ-009 rd_data_M  out  CORE_COUNT*REG_WIDTH  per-core load data, valid only while that core's ready_M is 1.
REQ-010 ready_M  out  CORE_COUNT  per-core one-cycle completion pulse.

Function
REQ-011 A core request is eligible when its op is 01 or 10 and its addr_M bank-id field equals BANK_ID; all other requests shall be ignored.
REQ-012 Requesters hold enable_M, addr_M and wr_data_M stable until their ready_M pulse; the block shall sample them only at grant.
REQ-013 FSM states: IDLE, ACCESS, RESP.
REQ-014 IDLE: no eligible request -> stay IDLE; otherwise latch winner index, op, offset, store data -> ACCESS.
REQ-015 ACCESS: store writes latched data to bank[offset]; load registers bank[offset] into the read register; -> RESP unconditionally.
REQ-016 RESP: ready_M[winner]=1 for exactly this cycle, rd_data_M slice of winner = read register (store: 0).
REQ-017 RESP arbitration: eligible requests excluding current winner are arbitrated; any remaining -> latch new winner, -> ACCESS; none -> IDLE.
REQ-018 Latency: request eligible in cycle N with FSM in IDLE -> ready_M pulse in cycle N+2; steady throughput one access per 2 cycles.
REQ-019 rd_data_M slices of non-winning cores and all slices outside RESP shall be 0; ready_M bits outside RESP shall be 0.
REQ-020 At most one ready_M bit shall be 1 in any cycle.
REQ-021 Load following store to the same offset, granted later, shall return the stored value (no stale read).
REQ-022 Request withdrawn illegally before ready_M: the latched transaction shall complete unaffected.

Reset
REQ-023 Reset low shall immediately force FSM to IDLE, ready_M to 0, rd_data_M to 0, read register to 0, round-robin pointer to 0.
REQ-024 Bank contents shall not be reset; reset mid-transaction shall abort it with no ready_M pulse; a store aborted in ACCESS before the clock edge shall not write.
REQ-025 After reset deasserts, the first grant shall be allowed on the first posedge.

Configuration
REQ-026 Macro MEM_ARB_RR_EN defined: round-robin, search starts at index after last winner, wrapping CORE_COUNT-1 -> 0; pointer updates in RESP.
REQ-027 Macro MEM_ARB_RR_EN undefined: fixed priority, lowest eligible index wins; no pointer register exists.

Verification
REQ-028 Core 1 store 8'h5A to offset 8'h10 of bank 0, then load same -> ready_M=4'b0010 at N+2 each; load returns 8'h5A.
REQ-029 Core 2 request with bank id 1 on BANK_ID=0 instance -> no ready_M pulse for 20 cycles, FSM stays IDLE.
REQ-030 Cores 0,1,3 load simultaneously, RR enabled -> pulses in order 0,1,3 on cycles N+2, N+4, N+6; without macro same order, core 0 repeated requests starve core 3.
REQ-031 enable_M slice 2'b11 from core 0 -> ignored, ready_M stays 0.
REQ-032 Reset asserted in ACCESS of store 8'hFF to offset 8'h03 after prior value 8'h11 -> no pulse; later load returns 8'h11.
REQ-033 Continuous requests from all four cores for 100 cycles -> ready_M one-hot or zero every cycle, 50 completions total.
